// File: rtl/mul_issue_ctrl.sv
// mul_issue_ctrl: queues tagged operand pairs and feeds them one at a time to a start/done
// sequential multiplier, returning each product with its tag on a valid/ready port.
module mul_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_src1,
    input  logic [7:0]       in_src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [7:0]       mul_src1,
    output logic [7:0]       mul_src2,
    input  logic [7:0]       mul_product,
    input  logic             mul_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_product,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy,
    output logic             err
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t           state, state_nxt;
    logic [7:0]       fifo_src1 [DEPTH];
    logic [7:0]       fifo_src2 [DEPTH];
    logic [TAG_W-1:0] fifo_tag  [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic [TAG_W-1:0] tag_r;
    logic             push, issue;

    assign in_ready = count != (AW+1)'(DEPTH);
    assign push     = in_valid && in_ready;
    assign busy     = state == WAIT || count != '0 || out_valid;

    // Issue only when the result register is free, so a pending result is never overwritten.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        if (state == IDLE && count != '0 && !out_valid) begin
            issue     = 1'b1;
            state_nxt = WAIT;
        end else if (state == WAIT && mul_done) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src1[wr_ptr] <= in_src1;
            fifo_src2[wr_ptr] <= in_src2;
            fifo_tag[wr_ptr]  <= in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            mul_start   <= 1'b0;
            mul_src1    <= '0;
            mul_src2    <= '0;
            tag_r       <= '0;
            out_valid   <= 1'b0;
            out_product <= '0;
            out_tag     <= '0;
            err         <= 1'b0;
        end else begin
            state     <= state_nxt;
            mul_start <= issue;
            count     <= count + (AW+1)'(push) - (AW+1)'(issue);
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (issue) begin
                rd_ptr   <= rd_ptr + AW'(1);
                mul_src1 <= fifo_src1[rd_ptr];
                mul_src2 <= fifo_src2[rd_ptr];
                tag_r    <= fifo_tag[rd_ptr];
            end
            if (state == WAIT && mul_done) begin
                out_valid   <= 1'b1;
                out_product <= mul_product;
                out_tag     <= tag_r;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (state == IDLE && mul_done)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// tb_mul_issue_ctrl: random and directed traffic against a count/queue model of the sequencer,
// with a behavioural multiplier of random latency answering mul_start.
module tb_mul_issue_ctrl;
    localparam int DEPTH = 4;
    localparam int TAG_W = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_src1 = '0;
    logic [7:0]       in_src2 = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             mul_start;
    logic [7:0]       mul_src1, mul_src2;
    logic [7:0]       mul_product = '0;
    logic             mul_done = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [7:0]       out_product;
    logic [TAG_W-1:0] out_tag;
    logic             busy, err;

    mul_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
        .mul_start(mul_start), .mul_src1(mul_src1), .mul_src2(mul_src2),
        .mul_product(mul_product), .mul_done(mul_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] p;
        p = $signed(a) * $signed(b);
        return p[7:0];
    endfunction

    // Model: requests not yet issued, operation in flight, pending result, sticky error.
    logic [15:0]        iq[$];
    logic [TAG_W+7:0]   rq[$];
    logic [TAG_W+15:0]  dq[$];
    int   queued = 0;
    bit   inflight = 0, ov = 0, err_exp = 0, exp_start = 0, stray = 0;
    int   lat = 0, iv_pct = 0, or_pct = 100, accepted = 0, starts = 0;

    task automatic step();
        logic [15:0] ops;
        bit push, issue, done;
        @(negedge clk);
        check("mul_start", mul_start, exp_start);
        if (exp_start && iq.size() > 0) begin
            ops = iq.pop_front();
            starts++;
            check("mul_src1", mul_src1, ops[15:8]);
            check("mul_src2", mul_src2, ops[7:0]);
        end
        check("in_ready", in_ready, queued < DEPTH);
        check("out_valid", out_valid, ov);
        if (ov && rq.size() > 0) begin
            check("out_product", out_product, rq[0][7:0]);
            check("out_tag", out_tag, rq[0][TAG_W+7:8]);
        end
        check("busy", busy, inflight || queued > 0 || ov);
        check("err", err, err_exp);
        if (dq.size() > 0) begin
            in_valid = 1'b1;
            {in_tag, in_src1, in_src2} = dq[0];
        end else begin
            in_valid = $urandom_range(99) < iv_pct;
            in_src1  = 8'($urandom);
            in_src2  = 8'($urandom);
            in_tag   = TAG_W'($urandom);
        end
        out_ready = $urandom_range(99) < or_pct;
        done = 0;
        if (inflight) begin
            if (lat == 0) done = 1;
            else lat--;
        end
        mul_done    = done || stray;
        mul_product = done ? smul(mul_src1, mul_src2) : 8'($urandom);
        push  = in_valid && queued < DEPTH;
        issue = !inflight && queued > 0 && !ov;
        if (push) begin
            if (dq.size() > 0) void'(dq.pop_front());
            iq.push_back({in_src1, in_src2});
            rq.push_back({in_tag, smul(in_src1, in_src2)});
            accepted++;
        end
        if (stray && !inflight) err_exp = 1;
        if (ov && out_ready) void'(rq.pop_front());
        ov = done ? 1'b1 : (ov && out_ready) ? 1'b0 : ov;
        if (issue) lat = $urandom_range(1, 4);
        inflight  = issue ? 1'b1 : done ? 1'b0 : inflight;
        queued    = queued + int'(push) - int'(issue);
        exp_start = issue;
    endtask

    task automatic drain(input string tag);
        iv_pct = 0;
        or_pct = 100;
        for (int i = 0; i < 300 && (rq.size() > 0 || ov || inflight); i++) step();
        check(tag, rq.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"}, mul_start, 0);
        check({tag, "_src"}, {mul_src1, mul_src2}, 0);
        check({tag, "_out"}, {out_valid, out_product, out_tag}, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_in_ready"}, in_ready, 1);
        check({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Directed products, including signed and overflowing cases.
        dq.push_back({2'd1, 8'h03, 8'h05});
        dq.push_back({2'd2, 8'hFD, 8'h05});
        dq.push_back({2'd3, 8'h7F, 8'h7F});
        check("exp_0f", rq.size(), 0);
        for (int i = 0; i < 60 && dq.size() > 0; i++) step();
        check("const_0f", smul(8'h03, 8'h05), 8'h0F);
        drain("directed_drain");
        check("directed_starts", starts, 3);

        // Backpressure: five accepted (one issued, four queued), then in_ready low.
        accepted = 0;
        starts = 0;
        iv_pct = 100;
        or_pct = 0;
        repeat (30) step();
        check("fill_accepted", accepted, DEPTH + 1);
        check("fill_starts", starts, 1);
        check("fill_in_ready", in_ready, 0);
        // Release the consumer while pushing: the FIFO pops and refills at full.
        or_pct = 100;
        repeat (40) step();
        iv_pct = 0;
        drain("fill_drain");

        // Tag order with random backpressure.
        for (int t = 0; t < 4; t++) dq.push_back({TAG_W'(t), 8'(8'h11 * (t + 1)), 8'(8'hF0 - t)});
        or_pct = 50;
        for (int i = 0; i < 60 && dq.size() > 0; i++) step();
        drain("tag_drain");

        // Random traffic.
        for (int r = 0; r < 6; r++) begin
            iv_pct = $urandom_range(10, 100);
            or_pct = $urandom_range(10, 100);
            repeat (250) step();
        end
        drain("random_drain");

        // Reset in the middle of an operation.
        iv_pct = 100;
        for (int i = 0; i < 50 && !inflight; i++) step();
        check("reached_wait", inflight, 1);
        #1 rst = 1'b1;
        in_valid = 1'b0;
        mul_done = 1'b0;
        iq.delete();
        rq.delete();
        dq.delete();
        queued = 0; inflight = 0; ov = 0; err_exp = 0; exp_start = 0; iv_pct = 0;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;

        // Stray done while idle sets the sticky error.
        stray = 1;
        step();
        stray = 0;
        repeat (5) step();
        check("err_sticky", err, 1);
        check("err_no_out", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
Request sequencer that sits between a valid/ready operand source and the 8-bit sequential multiplier (start/done handshake, 8-bit product).
- Buffers incoming operand pairs with a tag in a small FIFO.
- Issues one multiply at a time with a single-cycle start pulse.
- Waits for done, then presents the product and tag on a valid/ready result port.

Parameters:
- DEPTH, 4, operand FIFO depth; power of 2, at least 2.
- TAG_W, 2, width of the request tag carried alongside each operation.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  FIFO can accept a request.
- in_src1  in  8  multiplicand, two's complement.
- in_src2  in  8  multiplier, two's complement.
- in_tag  in  TAG_W  request tag.
- mul_start  out  1  start pulse to the multiplier.
- mul_src1  out  8  operand 1 to the multiplier.
- mul_src2  out  8  operand 2 to the multiplier.
- mul_product  in  8  multiplier result, valid when mul_done=1.
- mul_done  in  1  multiplier completion pulse.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_product  out  8  result product (low 8 bits of the signed product).
- out_tag  out  TAG_W  tag of the result.
- busy  out  1  operation in flight, FIFO non-empty, or out_valid=1.
- err  out  1  sticky flag: mul_done seen while no operation is in flight.

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; pointers and count = 0.
  - State = IDLE.
  - mul_start, mul_src1, mul_src2, out_valid, out_product, out_tag, err all = 0.
  - All outputs are registered except in_ready and busy.
- Reset mid-operation: the in-flight operation and all queued requests are discarded. The multiplier shares the system reset.
- FIFO:
  - in_ready = (count != DEPTH). No combinational dependence on a same-cycle pop.
  - Push when in_valid & in_ready. A push while full is impossible by the handshake; in_valid is ignored when in_ready=0.
  - Simultaneous push and pop: count is unchanged and both take effect.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, WAIT.
  - IDLE → WAIT when FIFO non-empty and out_valid=0. On that edge:
    - register the head entry into mul_src1, mul_src2 and an internal tag register;
    - pop the head;
    - set mul_start<=1.
  - WAIT:
    - mul_start<=0, so mul_start is high for exactly one cycle.
    - mul_src1 and mul_src2 are held stable until done.
    - On mul_done=1: out_product<=mul_product, out_tag<=tag register, out_valid<=1, state<=IDLE.
- The earliest next issue is the cycle after out_valid clears. Only one operation is in flight, and no issue happens while out_valid=1, so the output register is never overwritten.
- Output handshake:
  - out_valid, out_product and out_tag are held stable while out_ready=0.
  - On out_valid & out_ready, out_valid<=0.
  - If IDLE issues in the same cycle a result is accepted, that is allowed: the issue condition uses the registered out_valid, so the issue happens one cycle later.
- err: set to 1 on mul_done=1 while state=IDLE. The stray done is otherwise ignored. err is cleared only by reset.
- Arithmetic: no arithmetic is done here. The product passes through unmodified, and upper product bits are not available.
- Throughput: one result per (multiplier latency + 2) cycles at most. The issue→done latency is set entirely by the multiplier.

Test Plan:
- Single op: push src1=8'h03, src2=8'h05, tag=1 with out_ready=1 → exactly one mul_start pulse. After mul_done: out_valid=1, out_product=8'h0F, out_tag=1 for one cycle.
- Signed: src1=8'hFD (-3), src2=8'h05 → out_product=8'hF1. Also src1=8'h7F, src2=8'h7F → 8'h01.
- Fill/backpressure: out_ready=0, push back-to-back → 5 requests accepted (1 issued, 4 queued), then in_ready=0. The first result is held stable, and no second mul_start occurs until out_ready=1.
- Order and tags: push tags 0,1,2,3 with distinct operands, random out_ready → results emerge in push order with matching tags and products. There are no gaps or duplicates, and exactly one mul_start per result.
- Simultaneous push/pop at full: with in_valid=1 held, accept one result → the FIFO pops on the next issue while a new push lands. count stays at DEPTH and in_ready reflects it the next cycle.
- Reset/err: assert rst while in WAIT → all outputs 0, FIFO empty. After release, a forced mul_done=1 in IDLE → err=1 and stays 1; out_valid stays 0.
